// File: rtl/iic_target.sv
// I2C target with a 16-bit address pointer into an external byte memory.
// The master writes two address bytes and then data bytes. Each data byte
// produces one mem_we strobe and advances the pointer. A read (repeated
// START with R/W=1) streams bytes from the pointer and advances it on every
// master ACK. All bus decoding uses the synchronized copies of scl_i/sda_i.
module iic_target #(
  parameter logic [6:0] DEV_ADDR = 7'h14
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic        mem_we,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        busy,
  output logic        xfer_done
);

  typedef enum logic [3:0] {
    IDLE, DEV, DEV_ACK, AHI, AHI_ACK, ALO, ALO_ACK,
    WDAT, WDAT_ACK, RDAT, RDAT_ACK, IGNORE
  } state_t;

  logic scl_s1_q, scl_s2_q, scl_dl_q;
  logic sda_s1_q, sda_s2_q, sda_dl_q;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [7:0]  sr_q, sr_d;
  logic        sda_o_q, sda_o_d;
  logic        mem_we_q, mem_we_d;
  logic [15:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wdata_q, mem_wdata_d;
  logic        busy_q, busy_d;
  logic        xfer_done_q, xfer_done_d;

  logic       scl_rise, scl_fall, start_ev, stop_ev;
  logic [7:0] byte_in;

  // Two-flop synchronizers plus a delay flop for edge detection; idle bus is high.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_s1_q <= 1'b1; scl_s2_q <= 1'b1; scl_dl_q <= 1'b1;
      sda_s1_q <= 1'b1; sda_s2_q <= 1'b1; sda_dl_q <= 1'b1;
    end else begin
      scl_s1_q <= scl_i; scl_s2_q <= scl_s1_q; scl_dl_q <= scl_s2_q;
      sda_s1_q <= sda_i; sda_s2_q <= sda_s1_q; sda_dl_q <= sda_s2_q;
    end
  end

  assign scl_rise = scl_s2_q & ~scl_dl_q;
  assign scl_fall = ~scl_s2_q & scl_dl_q;
  assign start_ev = scl_s2_q & scl_dl_q & sda_dl_q & ~sda_s2_q;
  assign stop_ev  = scl_s2_q & scl_dl_q & ~sda_dl_q & sda_s2_q;
  assign byte_in  = {sr_q[6:0], sda_s2_q};

  // Next-state and next-output logic for the bus protocol FSM.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    sr_d        = sr_q;
    sda_o_d     = sda_o_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    busy_d      = busy_q;
    xfer_done_d = 1'b0;
    if (stop_ev) begin
      state_d     = IDLE;
      cnt_d       = 4'd0;
      sda_o_d     = 1'b1;
      busy_d      = 1'b0;
      xfer_done_d = busy_q;
    end else if (start_ev) begin
      // Repeated START keeps the pointer so a read can follow an address write.
      state_d = DEV;
      cnt_d   = 4'd0;
      sda_o_d = 1'b1;
    end else begin
      case (state_q)
        DEV, AHI, ALO, WDAT: begin
          if (scl_rise) begin
            sr_d  = byte_in;
            cnt_d = cnt_q + 4'd1;
            if (cnt_q == 4'd7) begin
              cnt_d = 4'd0;
              if (state_q == DEV) begin
                if (byte_in[7:1] == DEV_ADDR) begin
                  state_d = DEV_ACK;
                  busy_d  = 1'b1;
                end else begin
                  state_d = IGNORE;
                end
              end else if (state_q == AHI) begin
                mem_addr_d[15:8] = byte_in;
                state_d          = AHI_ACK;
              end else if (state_q == ALO) begin
                mem_addr_d[7:0] = byte_in;
                state_d         = ALO_ACK;
              end else begin
                mem_we_d    = 1'b1;
                mem_wdata_d = byte_in;
                state_d     = WDAT_ACK;
              end
            end
          end
        end
        DEV_ACK, AHI_ACK, ALO_ACK, WDAT_ACK: begin
          // cnt 0: waiting to pull the line low; cnt 1: holding the ACK.
          if (scl_fall) begin
            if (cnt_q == 4'd0) begin
              sda_o_d = 1'b0;
              cnt_d   = 4'd1;
            end else begin
              sda_o_d = 1'b1;
              cnt_d   = 4'd0;
              if (state_q == DEV_ACK) begin
                if (sr_q[0]) begin
                  // This fall also starts the first read byte.
                  state_d = RDAT;
                  sr_d    = {mem_rdata[6:0], 1'b0};
                  sda_o_d = mem_rdata[7];
                end else begin
                  state_d = AHI;
                end
              end else if (state_q == AHI_ACK) begin
                state_d = ALO;
              end else if (state_q == ALO_ACK) begin
                state_d = WDAT;
              end else begin
                mem_addr_d = mem_addr_q + 16'd1;
                state_d    = WDAT;
              end
            end
          end
        end
        RDAT: begin
          // cnt 8 marks a byte whose first bit is still to be loaded.
          if (scl_fall) begin
            if (cnt_q == 4'd8) begin
              sr_d    = {mem_rdata[6:0], 1'b0};
              sda_o_d = mem_rdata[7];
              cnt_d   = 4'd0;
            end else if (cnt_q == 4'd7) begin
              sda_o_d = 1'b1;
              cnt_d   = 4'd0;
              state_d = RDAT_ACK;
            end else begin
              sda_o_d = sr_q[7];
              sr_d    = {sr_q[6:0], 1'b0};
              cnt_d   = cnt_q + 4'd1;
            end
          end
        end
        RDAT_ACK: begin
          if (scl_rise) begin
            if (!sda_s2_q) begin
              mem_addr_d = mem_addr_q + 16'd1;
              cnt_d      = 4'd8;
              state_d    = RDAT;
            end else begin
              state_d = IGNORE;
            end
          end
        end
        IDLE, IGNORE: begin
          sda_o_d = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and registered outputs; reset releases the bus line at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      sr_q        <= 8'd0;
      sda_o_q     <= 1'b1;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 16'd0;
      mem_wdata_q <= 8'd0;
      busy_q      <= 1'b0;
      xfer_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      sr_q        <= sr_d;
      sda_o_q     <= sda_o_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      xfer_done_q <= xfer_done_d;
    end
  end

  assign sda_o     = sda_o_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign xfer_done = xfer_done_q;

endmodule
